// File: rtl/rm_ram_pkg.sv
// Shared constants and types for the ping-pong bank RAM.
package rm_ram_pkg;

   // Supported range of the rd_en-to-rd_data latency.
   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 3;

   // full_cnt counts handed-over banks: 0, 1 or 2.
   localparam int FULL_CNT_W = 2;

   typedef logic [FULL_CNT_W-1:0] full_cnt_t;

   localparam full_cnt_t FULL_CNT_EMPTY = 2'd0;
   localparam full_cnt_t FULL_CNT_MAX   = 2'd2;

endpackage

// File: rtl/rm_ram_bank_mem.sv
// Two-bank storage: inferred simple dual-port array with a
// READ_LATENCY-stage read data/valid pipeline. The last data stage only
// loads on a valid read, so the output holds between reads.
module rm_ram_bank_mem
   import rm_ram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int PADDR_WIDTH  = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [PADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic                   re,
   input  logic [PADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]  rdata,
   output logic                   rvalid
);

   logic [DATA_WIDTH-1:0]   mem_r [0:(2**PADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0]   data_r [READ_LATENCY];
   logic [READ_LATENCY-1:0] valid_r;

   // Write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read pipeline: stage 0 captures the array, later stages shift on valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            data_r[i] <= '0;
         end
      end else begin
         valid_r[0] <= re;
         if (re) begin
            data_r[0] <= mem_r[raddr];
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_r[i] <= valid_r[i-1];
            if (valid_r[i-1]) begin
               data_r[i] <= data_r[i-1];
            end
         end
      end
   end

   assign rdata  = data_r[READ_LATENCY-1];
   assign rvalid = valid_r[READ_LATENCY-1];

endmodule

// File: rtl/pingpong_rm_ram.sv
// Ping-pong RAM: producer fills one bank while the consumer drains the
// other; wr_done / rd_done hand banks across.
// Optional protocol checker: define RM_RAM_PROTOCOL_CHK_EN to enable the
// sticky err flag; otherwise err is tied low.
module pingpong_rm_ram
   import rm_ram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 11,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_done,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_done,
   output logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  err
);

   logic      wr_bank_r, rd_bank_r;
   logic      wr_bank_s, rd_bank_s;
   full_cnt_t full_cnt_r, full_cnt_s;
   logic      wr_ready_r, rd_ready_r;
   logic      wr_acc_s, wdone_acc_s, rd_acc_s, rdone_acc_s;

   assign wr_acc_s    = wr_en   & wr_ready_r;
   assign wdone_acc_s = wr_done & wr_ready_r;
   assign rd_acc_s    = rd_en   & rd_ready_r;
   assign rdone_acc_s = rd_done & rd_ready_r;

   // Next bank pointers and occupancy from accepted hand-overs.
   always_comb begin
      wr_bank_s  = wr_bank_r;
      rd_bank_s  = rd_bank_r;
      full_cnt_s = full_cnt_r;
      if (wdone_acc_s) begin
         wr_bank_s = ~wr_bank_r;
      end else begin
         wr_bank_s = wr_bank_r;
      end
      if (rdone_acc_s) begin
         rd_bank_s = ~rd_bank_r;
      end else begin
         rd_bank_s = rd_bank_r;
      end
      case ({wdone_acc_s, rdone_acc_s})
         2'b10:   full_cnt_s = full_cnt_r + 2'd1;
         2'b01:   full_cnt_s = full_cnt_r - 2'd1;
         default: full_cnt_s = full_cnt_r;
      endcase
   end

   // Control state; ready flags are registered from the next occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_r  <= 1'b0;
         rd_bank_r  <= 1'b0;
         full_cnt_r <= FULL_CNT_EMPTY;
         wr_ready_r <= 1'b1;
         rd_ready_r <= 1'b0;
      end else begin
         wr_bank_r  <= wr_bank_s;
         rd_bank_r  <= rd_bank_s;
         full_cnt_r <= full_cnt_s;
         wr_ready_r <= (full_cnt_s != FULL_CNT_MAX);
         rd_ready_r <= (full_cnt_s != FULL_CNT_EMPTY);
      end
   end

   assign wr_ready = wr_ready_r;
   assign rd_ready = rd_ready_r;

   // The read bank is captured with rd_en, so a same-cycle rd_done cannot
   // redirect it. Both sides ready implies distinct banks: no collisions.
   rm_ram_bank_mem #(
      .DATA_WIDTH   (DATA_WIDTH),
      .PADDR_WIDTH  (ADDR_WIDTH + 1),
      .READ_LATENCY (READ_LATENCY)
   ) u_mem (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wr_acc_s),
      .waddr  ({wr_bank_r, wr_addr}),
      .wdata  (wr_data),
      .re     (rd_acc_s),
      .raddr  ({rd_bank_r, rd_addr}),
      .rdata  (rd_data),
      .rvalid (rd_valid)
   );

`ifdef RM_RAM_PROTOCOL_CHK_EN
   logic err_r;
   logic viol_s;

   assign viol_s = (~wr_ready_r & (wr_en | wr_done)) |
                   (~rd_ready_r & (rd_en | rd_done));

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | viol_s;
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

endmodule
